// File: rtl/drac_reset_sequencer.sv
// Multi-hart reset/wake-up sequencer: timed wake-up, staggered hart release, per-hart soft reset.
// Optional per-hart watchdog enabled by defining DRAC_RST_SEQ_WDT_EN.
module drac_reset_sequencer #(
  parameter int unsigned NumHarts      = 1,
  parameter int unsigned WakeUpCycles  = 32768,
  parameter int unsigned StaggerCycles = 4,
  parameter int unsigned SoftRstCycles = 16,
  parameter int unsigned WdtCycles     = 1048576
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHarts-1:0] soft_rst_req_i,
  output logic [NumHarts-1:0] soft_rst_ack_o,
  output logic [NumHarts-1:0] hart_rstn_o,
  output logic                grst_l_o,
  output logic                all_running_o,
  input  logic [NumHarts-1:0] heartbeat_i,
  output logic [NumHarts-1:0] wdt_fired_o
);

  localparam int unsigned WakeW = $clog2(WakeUpCycles + 1);
  localparam int unsigned SrW   = $clog2(SoftRstCycles + 1);
  localparam int unsigned IdxW  = (NumHarts > 1) ? $clog2(NumHarts) : 1;
  localparam int unsigned StgW  = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;

  localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeUpCycles);
  localparam logic [SrW-1:0]   SrLast   = SrW'(SoftRstCycles);
  localparam logic [StgW-1:0]  StgLast  = StgW'((StaggerCycles > 0) ? StaggerCycles - 1 : 0);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumHarts - 1);
  localparam bit               AllAtOnce = (NumHarts == 1) || (StaggerCycles == 0);

  typedef enum logic [1:0] {WAKE, RELEASE, RUN} state_e;

  state_e              state_q, state_d;
  logic [WakeW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [StgW-1:0]     stg_cnt_q, stg_cnt_d;
  logic [NumHarts-1:0] rstn_q, rstn_d;
  logic [NumHarts-1:0] ack_q, ack_d;
  logic                all_run_q, all_run_d;
  logic                grst_q;
  logic [SrW-1:0]      sr_cnt_q [NumHarts];
  logic [SrW-1:0]      sr_cnt_d [NumHarts];
  logic [NumHarts-1:0] wdt_trig;
  logic [NumHarts-1:0] sr_start;

  // A watchdog expiry is treated exactly like an external request, so both merge here.
  assign sr_start = soft_rst_req_i | wdt_trig;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idx_d      = idx_q;
    stg_cnt_d  = stg_cnt_q;
    rstn_d     = rstn_q;
    ack_d      = '0;
    sr_cnt_d   = sr_cnt_q;
    unique case (state_q)
      WAKE: begin
        if (wake_cnt_q == WakeLast) begin
          rstn_d[0] = 1'b1;
          if (AllAtOnce) begin
            rstn_d  = '1;
            state_d = RUN;
          end else begin
            state_d   = RELEASE;
            idx_d     = IdxW'(1);
            stg_cnt_d = '0;
          end
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (stg_cnt_q == StgLast) begin
          stg_cnt_d = '0;
          for (int unsigned h = 0; h < NumHarts; h++) begin
            if (IdxW'(h) == idx_q) rstn_d[h] = 1'b1;
          end
          if (idx_q == IdxLast) state_d = RUN;
          else                  idx_d   = idx_q + 1'b1;
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // In RUN a low hart_rstn bit can only mean that hart is in soft reset.
        for (int unsigned h = 0; h < NumHarts; h++) begin
          if (rstn_q[h]) begin
            if (sr_start[h]) begin
              rstn_d[h]   = 1'b0;
              sr_cnt_d[h] = SrW'(1);
            end
          end else if (sr_cnt_q[h] == SrLast) begin
            rstn_d[h]   = 1'b1;
            ack_d[h]    = 1'b1;
            sr_cnt_d[h] = '0;
          end else begin
            sr_cnt_d[h] = sr_cnt_q[h] + 1'b1;
          end
        end
      end
      default: state_d = WAKE;
    endcase
    all_run_d = (state_d == RUN) && (&rstn_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAKE;
      wake_cnt_q <= '0;
      idx_q      <= '0;
      stg_cnt_q  <= '0;
      rstn_q     <= '0;
      ack_q      <= '0;
      all_run_q  <= 1'b0;
      grst_q     <= 1'b0;
      for (int unsigned h = 0; h < NumHarts; h++) sr_cnt_q[h] <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idx_q      <= idx_d;
      stg_cnt_q  <= stg_cnt_d;
      rstn_q     <= rstn_d;
      ack_q      <= ack_d;
      all_run_q  <= all_run_d;
      grst_q     <= 1'b1;
      sr_cnt_q   <= sr_cnt_d;
    end
  end

`ifdef DRAC_RST_SEQ_WDT_EN
  localparam int unsigned     WdtW    = $clog2(WdtCycles);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WdtCycles - 1);

  logic [WdtW-1:0]     wdt_cnt_q [NumHarts];
  logic [WdtW-1:0]     wdt_cnt_d [NumHarts];
  logic [NumHarts-1:0] fired_q, fired_d;

  always_comb begin
    wdt_trig  = '0;
    wdt_cnt_d = wdt_cnt_q;
    fired_d   = fired_q;
    for (int unsigned h = 0; h < NumHarts; h++) begin
      wdt_trig[h] = rstn_q[h] && !heartbeat_i[h] && (wdt_cnt_q[h] == WdtLast);
      if (!rstn_q[h] || heartbeat_i[h] || wdt_trig[h]) wdt_cnt_d[h] = '0;
      else                                            wdt_cnt_d[h] = wdt_cnt_q[h] + 1'b1;
      if (wdt_trig[h] && (state_q == RUN)) fired_d[h] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fired_q <= '0;
      for (int unsigned h = 0; h < NumHarts; h++) wdt_cnt_q[h] <= '0;
    end else begin
      fired_q   <= fired_d;
      wdt_cnt_q <= wdt_cnt_d;
    end
  end

  assign wdt_fired_o = fired_q;
`else
  logic unused_heartbeat;
  assign unused_heartbeat = ^heartbeat_i;
  assign wdt_trig         = '0;
  assign wdt_fired_o      = '0;
`endif

  assign hart_rstn_o    = rstn_q;
  assign soft_rst_ack_o = ack_q;
  assign all_running_o  = all_run_q;
  assign grst_l_o       = grst_q;

endmodule

// File: tb/tb_drac_reset_sequencer.sv
// Directed bench for drac_reset_sequencer: three instances (1 hart, 4 staggered, 4 simultaneous).
module tb_drac_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, ack_a, rstn_a, grst_a, run_a, wdt_a;
  logic [3:0] req_b, ack_b, rstn_b, hb_b, wdt_b;
  logic       grst_b, run_b;
  logic [3:0] req_c, ack_c, rstn_c, wdt_c;
  logic       grst_c, run_c;

  drac_reset_sequencer #(.NumHarts(1), .WakeUpCycles(8)) u_a (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(req_a), .soft_rst_ack_o(ack_a),
    .hart_rstn_o(rstn_a), .grst_l_o(grst_a), .all_running_o(run_a),
    .heartbeat_i(1'b1), .wdt_fired_o(wdt_a));

  drac_reset_sequencer #(.NumHarts(4), .WakeUpCycles(8), .StaggerCycles(3),
                         .SoftRstCycles(16), .WdtCycles(10)) u_b (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(req_b), .soft_rst_ack_o(ack_b),
    .hart_rstn_o(rstn_b), .grst_l_o(grst_b), .all_running_o(run_b),
    .heartbeat_i(hb_b), .wdt_fired_o(wdt_b));

  drac_reset_sequencer #(.NumHarts(4), .WakeUpCycles(8), .StaggerCycles(0)) u_c (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(req_c), .soft_rst_ack_o(ack_c),
    .hart_rstn_o(rstn_c), .grst_l_o(grst_c), .all_running_o(run_c),
    .heartbeat_i(4'hF), .wdt_fired_o(wdt_c));

  typedef struct {
    int         cyc;
    logic [3:0] req_b;
    logic       rstn_a;
    logic       run_a;
    logic [3:0] rstn_b;
    logic       run_b;
    logic [3:0] ack_b;
    logic [3:0] rstn_c;
    logic       run_c;
    logic       grst;
  } vec_t;

  vec_t tbl [13];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [3:0] exp_b;
    logic       bad1;
    rst = 1'b1; req_a = 1'b0; req_b = '0; req_c = '0; hb_b = 4'hF;

    //     cyc req     rA   runA rB      runB ackB    rC      runC grst
    tbl[0]  = '{0,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{8,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[3]  = '{9,  4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[4]  = '{11, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[5]  = '{12, 4'b0000, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[6]  = '{13, 4'b0010, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[7]  = '{14, 4'b0000, 1'b1, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[8]  = '{15, 4'b0000, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[9]  = '{17, 4'b0000, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[10] = '{18, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[11] = '{19, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1};
    tbl[12] = '{30, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1};

    step(); step();
    cyc = 0;
    rst = 1'b0;

    // Wake-up and staggered release; the hart-1 request at cycle 13 lands in RELEASE.
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].cyc) begin
        step();
        req_b = '0;
      end
      chk("rstn_a", 32'(rstn_a), 32'(tbl[i].rstn_a));
      chk("run_a",  32'(run_a),  32'(tbl[i].run_a));
      chk("rstn_b", 32'(rstn_b), 32'(tbl[i].rstn_b));
      chk("run_b",  32'(run_b),  32'(tbl[i].run_b));
      chk("ack_b",  32'(ack_b),  32'(tbl[i].ack_b));
      chk("rstn_c", 32'(rstn_c), 32'(tbl[i].rstn_c));
      chk("run_c",  32'(run_c),  32'(tbl[i].run_c));
      chk("grst",   32'({grst_a, grst_b, grst_c}), 32'({3{tbl[i].grst}}));
      req_b = tbl[i].req_b;
    end

    // Single-cycle soft reset on hart 2; a second pulse mid-reset is ignored.
    req_b = 4'b0100;
    for (int k = 1; k <= 18; k++) begin
      step();
      req_b = (k == 5) ? 4'b0100 : 4'b0000;
      chk("sr2_rstn", 32'(rstn_b), (k <= 16) ? 32'hB : 32'hF);
      chk("sr2_ack",  32'(ack_b),  (k == 17) ? 32'h4 : 32'h0);
      chk("sr2_run",  32'(run_b),  (k <= 16) ? 32'h0 : 32'h1);
    end

    // Harts 0 and 3 together; hart 0 request held through its ack restarts it.
    req_b = 4'b1001;
    for (int k = 1; k <= 18; k++) begin
      step();
      req_b = (k <= 17) ? 4'b0001 : 4'b0000;
      exp_b = (k <= 16) ? 4'b0110 : ((k == 17) ? 4'b1111 : 4'b1110);
      chk("sr03_rstn", 32'(rstn_b), 32'(exp_b));
      chk("sr03_ack",  32'(ack_b),  (k == 17) ? 32'h9 : 32'h0);
      chk("sr03_run",  32'(run_b),  (k == 17) ? 32'h1 : 32'h0);
    end
    for (int k = 19; k <= 34; k++) step();
    chk("sr0_level_ack",  32'(ack_b),  32'h1);
    chk("sr0_level_rstn", 32'(rstn_b), 32'hF);

    // Global reset while hart 1 is in soft reset, then the full wake-up repeats.
    req_b = 4'b0010;
    step();
    req_b = '0;
    step(); step();
    chk("pre_rst_rstn", 32'(rstn_b), 32'hD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rstn", 32'({rstn_a, rstn_b, rstn_c}), 32'h0);
    chk("rst_misc", 32'({ack_b, run_b, grst_b, wdt_b, run_c, grst_a}), 32'h0);
    cyc = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      for (int h = 0; h < 4; h++) exp_b[h] = (k >= 9 + 3 * h);
      chk("rewake_rstn", 32'(rstn_b), 32'(exp_b));
      chk("rewake_run",  32'(run_b),  (k >= 18) ? 32'h1 : 32'h0);
      chk("rewake_ack",  32'(ack_b),  32'h0);
      chk("rewake_grst", 32'(grst_b), 32'h1);
    end

`ifdef DRAC_RST_SEQ_WDT_EN
    // Hart 0 stops feeding the watchdog; expiry forces a soft reset 10 cycles later.
    hb_b = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("wdt_rstn0", 32'(rstn_b[0]), (k < 10) ? 32'h1 : 32'h0);
      chk("wdt_fired", 32'(wdt_b),     (k < 10) ? 32'h0 : 32'h1);
    end
    bad1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      hb_b[1] = (i % 5 == 0);
      if (rstn_b[1] !== 1'b1 || wdt_b[1] !== 1'b0) bad1 = 1'b1;
    end
    chk("wdt_hb_fed",     32'(bad1),     32'h0);
    chk("wdt_fired0_stk", 32'(wdt_b[0]), 32'h1);
`else
    bad1 = 1'b0;
    hb_b = 4'h0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rstn_b !== 4'hF || wdt_b !== 4'h0) bad1 = 1'b1;
    end
    chk("no_wdt_quiet", 32'(bad1), 32'h0);
    chk("no_wdt_fired", 32'({wdt_a, wdt_b, wdt_c}), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
